multicycle_sequencer: RTL

- Multi-cycle control FSM that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB for the 32-bit datapath.
- Holds the PC and the instruction register (IR); the IR drives the field decoder.
- Runs the request/acknowledge handshakes to instruction and data memory.
- Gates the register-file and memory write strobes so each fires once per instruction, in the correct cycle.

---
 rtl/proc_pkg.sv | 40 ++++
 rtl/multicycle_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcode constants, sequencer state encoding and opcode classification
package proc_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam int OPC_HI = 18;
    localparam int OPC_LO = 15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_HALT
    } op_class_t;

    // Anything that is not a memory op or HALT is treated as an ALU op.
    function automatic op_class_t classify(input logic [31:0] instr);
        logic [3:0] opc;
        opc = instr[OPC_HI:OPC_LO];
        case (opc)
            OP_LOAD:  return CLS_LOAD;
            OP_STORE: return CLS_STORE;
            OP_HALT:  return CLS_HALT;
            default:  return CLS_ALU;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with PC, IR and retire counter
module multicycle_sequencer
    import proc_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             wb_sel,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_retired;
    op_class_t        w_cls;
    logic             w_fetch_done;
    logic             w_retire;

    assign w_cls        = classify(r_ir);
    assign w_fetch_done = (r_state == FETCH) && imem_ack;
    // A STORE retires on its data ack; everything else retires in WB.
    assign w_retire     = (r_state == WB) ||
                          ((r_state == MEM) && dmem_ack && (w_cls == CLS_STORE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        busy     = 1'b1;
        halted   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next = DECODE;
            end
            DECODE: begin
                w_next = (w_cls == CLS_HALT) ? HALT : EXEC;
            end
            EXEC: begin
                alu_en = 1'b1;
                w_next = ((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_cls == CLS_STORE);
                if (dmem_ack) w_next = (w_cls == CLS_STORE) ? FETCH : WB;
            end
            WB: begin
                rf_we  = 1'b1;
                wb_sel = (w_cls == CLS_LOAD);
                w_next = FETCH;
            end
            HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            if (w_fetch_done) begin
                r_ir <= imem_rdata;
                r_pc <= r_pc + PC_ONE;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_ONE;
            end
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign ir        = r_ir;
    assign retired   = r_retired;

endmodule
